// File: rtl/fifo_drain_sram_writer.sv
// Paced drain of the UART RX FIFO: packs byte pairs into 16-bit words and
// writes them to the SRAM controller over a req/ack handshake.
module fifo_drain_sram_writer #(
   parameter int unsigned PACE_PERIOD = 10000,
   parameter int unsigned PACE_W      = 27,
   parameter int unsigned ADDR_W      = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [7:0]        fifo_dout,
   output logic              fifo_rd_en,
   input  logic              flush,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              wrapped
);

   typedef enum logic [1:0] {IDLE, RD, CAP, WRITE} state_t;

   state_t            state;
   logic [PACE_W-1:0] pace_cnt;
   logic              half;
   logic              tick_c;

   assign tick_c = (pace_cnt == PACE_W'(PACE_PERIOD - 1));

   // Free-running pace counter; one pop opportunity per wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pace_cnt <= '0;
      end else if (tick_c) begin
         pace_cnt <= '0;
      end else begin
         pace_cnt <= pace_cnt + PACE_W'(1);
      end
   end

   // Pop / capture / write sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         half       <= 1'b0;
         fifo_rd_en <= 1'b0;
         wr_req     <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wrapped    <= 1'b0;
      end else begin
         fifo_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (tick_c && !fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                  state      <= RD;
               end else if (!tick_c && flush && half) begin
                  // Odd byte out: pad the upper half with zero.
                  wr_data[15:8] <= 8'h00;
                  half          <= 1'b0;
                  wr_req        <= 1'b1;
                  state         <= WRITE;
               end
            end
            RD: begin
               state <= CAP;
            end
            CAP: begin
               if (!half) begin
                  wr_data[7:0] <= fifo_dout;
                  half         <= 1'b1;
                  state        <= IDLE;
               end else begin
                  wr_data[15:8] <= fifo_dout;
                  half          <= 1'b0;
                  wr_req        <= 1'b1;
                  state         <= WRITE;
               end
            end
            WRITE: begin
               if (wr_ack) begin
                  wr_req  <= 1'b0;
                  wr_addr <= wr_addr + ADDR_W'(1);
                  if (&wr_addr) begin
                     wrapped <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_sram_writer.sv
// Randomized bench for fifo_drain_sram_writer against a queue-based model of
// popped bytes, expected words and address sequence.
module tb_fifo_drain_sram_writer;

   localparam int unsigned PACE_PERIOD = 4;
   localparam int unsigned PACE_W      = 3;
   localparam int unsigned ADDR_W      = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fifo_empty;
   logic [7:0]        fifo_dout;
   logic              fifo_rd_en;
   logic              flush;
   logic              wr_req;
   logic              wr_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              wrapped;

   fifo_drain_sram_writer #(
      .PACE_PERIOD(PACE_PERIOD),
      .PACE_W     (PACE_W),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rd_en(fifo_rd_en),
      .flush     (flush),
      .wr_req    (wr_req),
      .wr_ack    (wr_ack),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wrapped   (wrapped)
   );

   always #5 clk = ~clk;

   int                n_chk  = 0;
   int                n_pass = 0;
   int                n_wr   = 0;
   int                cyc    = 0;
   int                last_rd = -1;
   logic [7:0]        q[$];
   logic [7:0]        pend[$];
   logic [ADDR_W-1:0] exp_addr = '0;
   logic              exp_wrapped = 1'b0;
   logic [15:0]       last_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // One clock: note what the coming posedge will do, then check the result.
   task automatic tick_clk();
      logic              rst_seen, fire, stall, pop;
      logic [ADDR_W-1:0] a0;
      logic [15:0]       d0, exp_d;
      int                pop_cyc;
      rst_seen = rst_n;
      fire     = rst_n && wr_req && wr_ack;
      stall    = rst_n && wr_req && !wr_ack;
      pop      = rst_n && fifo_rd_en;
      a0       = wr_addr;
      d0       = wr_data;
      pop_cyc  = cyc;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!rst_seen) begin
         q.delete();
         pend.delete();
         exp_addr    = '0;
         exp_wrapped = 1'b0;
         last_rd     = -1;
         fifo_empty  = 1'b1;
         check("reset_outputs", {fifo_rd_en, wr_req, wr_addr, wr_data, wrapped}, '0);
         return;
      end
      if (fire) begin
         exp_d = 16'hxxxx;
         if (pend.size() >= 2) begin
            exp_d = {pend[1], pend[0]};
            void'(pend.pop_front());
            void'(pend.pop_front());
         end else if (pend.size() == 1) begin
            exp_d = {8'h00, pend[0]};
            void'(pend.pop_front());
         end
         check("write_addr", 64'(a0), 64'(exp_addr));
         check("write_data", 64'(d0), 64'(exp_d));
         last_data = d0;
         n_wr++;
         if (exp_addr == '1) exp_wrapped = 1'b1;
         exp_addr = exp_addr + 1'b1;
      end
      if (stall) check("stall_hold", {wr_req, wr_addr, wr_data}, {1'b1, a0, d0});
      if (pop) begin
         if (q.size() == 0) begin
            check("pop_when_empty", 1, 0);
         end else begin
            fifo_dout = q.pop_front();
            pend.push_back(fifo_dout);
         end
         if (last_rd >= 0) begin
            check("pop_spacing_ok",
                  64'(((pop_cyc - last_rd) % PACE_PERIOD == 0) && (pop_cyc - last_rd >= PACE_PERIOD)), 1);
         end
         last_rd = pop_cyc;
      end
      fifo_empty = (q.size() == 0);
      check("addr_now", 64'(wr_addr), 64'(exp_addr));
      check("wrapped_now", 64'(wrapped), 64'(exp_wrapped));
      if (wr_req) check("no_pop_in_write", 64'(fifo_rd_en), 0);
   endtask

   task automatic wait_writes(input int target, input int limit, input string tag);
      int k = 0;
      while (n_wr < target && k < limit) begin
         tick_clk();
         k++;
      end
      check(tag, 64'(n_wr >= target), 1);
   endtask

   task automatic wait_req(input int limit, input string tag);
      int k = 0;
      while (!wr_req && k < limit) begin
         tick_clk();
         k++;
      end
      check(tag, 64'(wr_req), 1);
   endtask

   initial begin
      logic [ADDR_W-1:0] a_before;
      int                k, base;
      rst_n = 1'b0; flush = 1'b0; wr_ack = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
      @(negedge clk);
      repeat (3) tick_clk();
      rst_n = 1'b1;

      // Reset while a write is stalled.
      push(8'h11); push(8'h22);
      wait_req(40, "req_before_reset");
      rst_n = 1'b0;
      repeat (3) tick_clk();
      rst_n = 1'b1;
      tick_clk();

      // Pacing and packing.
      wr_ack = 1'b1;
      push(8'hA5); push(8'h3C);
      wait_writes(n_wr + 1, 40, "t2_write_done");
      check("t2_data", 64'(last_data), 64'h3CA5);
      tick_clk();
      check("t2_addr_after", 64'(wr_addr), 1);

      // Backpressure with further bytes waiting.
      wr_ack = 1'b0;
      for (int i = 0; i < 4; i++) push(8'($urandom));
      wait_req(40, "t3_req");
      for (int i = 0; i < 20; i++) begin
         check("t3_no_pop", 64'(fifo_rd_en), 0);
         tick_clk();
      end
      a_before = wr_addr;
      wr_ack = 1'b1;
      wait_writes(n_wr + 1, 5, "t3_ack_write");
      check("t3_one_incr", 64'(wr_addr), 64'(a_before + 1'b1));
      wait_writes(n_wr + 1, 40, "t3_second_write");

      // Empty FIFO.
      for (int i = 0; i < 50; i++) begin
         tick_clk();
         check("t4_idle", {fifo_rd_en, wr_req}, 0);
      end

      // Flush of a single byte.
      push(8'h7E);
      k = 0;
      while (pend.size() == 0 && k < 40) begin tick_clk(); k++; end
      tick_clk();
      flush = 1'b1;
      wait_writes(n_wr + 1, 20, "t5_flush_write");
      flush = 1'b0;
      check("t5_data", 64'(last_data), 64'h007E);
      push(8'h5A); push(8'hC3);
      wait_writes(n_wr + 1, 40, "t5_repack");
      check("t5_repack_data", 64'(last_data), 64'hC35A);

      // Randomized traffic until the address wraps.
      base = n_wr;
      k = 0;
      while (n_wr < base + 17 && k < 3000) begin
         wr_ack = 1'($urandom_range(0, 1));
         flush  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0 && q.size() < 8) push(8'($urandom));
         tick_clk();
         k++;
      end
      check("t6_17_writes", 64'(n_wr >= base + 17), 1);
      wr_ack = 1'b1;
      flush  = 1'b1;
      k = 0;
      while ((q.size() != 0 || pend.size() != 0 || wr_req) && k < 400) begin
         tick_clk();
         k++;
      end
      check("t6_drained", 64'(pend.size() + q.size()), 0);
      check("t6_wrapped", 64'(wrapped), 1);
      flush = 1'b0;
      tick_clk();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
